// File: rtl/vpu_lane_ctrl.sv
// vpu_lane_ctrl: sequences one request through a vector lane (IDLE/ISSUE/WAIT/RESP) and returns the result.
// Optional WAIT-state timeout is compiled in with `define VPU_LANE_CTRL_TIMEOUT_EN.
module vpu_lane_ctrl #(
    parameter int OPERAND_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [3:0]                       req_opcode_i,
    input  logic [2:0][OPERAND_WIDTH-1:0]    req_operand_i,
    input  logic [2:0]                       req_operand_valid_i,
    output logic                             lane_start_o,
    output logic [8:0]                       lane_op_o,
    output logic [2:0][OPERAND_WIDTH-1:0]    lane_operand_o,
    output logic [2:0]                       lane_operand_valid_o,
    input  logic [OPERAND_WIDTH-1:0]         lane_dout_i,
    input  logic                             lane_done_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]         rsp_data_o,
    output logic                             rsp_err_o,
    output logic                             busy_o,
    output logic [15:0]                      done_cnt_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                          state_q, state_d;
    logic [8:0]                      op_q, op_d;
    logic [2:0][OPERAND_WIDTH-1:0]   operand_q, operand_d;
    logic [2:0]                      opvld_q, opvld_d;
    logic [OPERAND_WIDTH-1:0]        rsp_data_q, rsp_data_d;
    logic                            rsp_err_q, rsp_err_d;
    logic [15:0]                     done_cnt_q, done_cnt_d;
    logic                            legal;

`ifdef VPU_LANE_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    function automatic logic [8:0] op_onehot(input logic [3:0] opc);
        op_onehot = 9'd1 << opc;
    endfunction

    assign legal = (req_opcode_i <= 4'd8);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        operand_d  = operand_q;
        opvld_d    = opvld_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        done_cnt_d = done_cnt_q;
`ifdef VPU_LANE_CTRL_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (legal) begin
                        op_d      = op_onehot(req_opcode_i);
                        operand_d = req_operand_i;
                        opvld_d   = req_operand_valid_i;
                        state_d   = ISSUE;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            ISSUE: begin
`ifdef VPU_LANE_CTRL_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                // A lane may answer in the same cycle it is started.
                if (lane_done_i) begin
                    rsp_data_d = lane_dout_i;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lane_done_i) begin
                    rsp_data_d = lane_dout_i;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
`ifdef VPU_LANE_CTRL_TIMEOUT_EN
                else if (tmo_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    op_d       = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            operand_q  <= '0;
            opvld_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            done_cnt_q <= '0;
`ifdef VPU_LANE_CTRL_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            operand_q  <= operand_d;
            opvld_q    <= opvld_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            done_cnt_q <= done_cnt_d;
`ifdef VPU_LANE_CTRL_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    // Ready is masked while reset is held so every output reads 0 during reset.
    assign req_ready_o          = (state_q == IDLE) && !rst;
    assign lane_start_o         = (state_q == ISSUE);
    assign lane_op_o            = op_q;
    assign lane_operand_o       = operand_q;
    assign lane_operand_valid_o = opvld_q;
    assign rsp_valid_o          = (state_q == RESP);
    assign rsp_data_o           = rsp_data_q;
    assign rsp_err_o            = rsp_err_q;
    assign busy_o               = (state_q != IDLE);
    assign done_cnt_o           = done_cnt_q;

endmodule

// File: tb/tb_vpu_lane_ctrl.sv
// Randomized self-checking bench for vpu_lane_ctrl with a transaction-level reference model.
// Timeout scenarios are exercised when VPU_LANE_CTRL_TIMEOUT_EN is defined.
module tb_vpu_lane_ctrl;
    localparam int W   = 32;
    localparam int TMO = 64;
`ifdef VPU_LANE_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [3:0]           req_opcode_i;
    logic [2:0][W-1:0]    req_operand_i;
    logic [2:0]           req_operand_valid_i;
    logic                 lane_start_o;
    logic [8:0]           lane_op_o;
    logic [2:0][W-1:0]    lane_operand_o;
    logic [2:0]           lane_operand_valid_o;
    logic [W-1:0]         lane_dout_i = '0;
    logic                 lane_done_i = 1'b0;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [W-1:0]         rsp_data_o;
    logic                 rsp_err_o;
    logic                 busy_o;
    logic [15:0]          done_cnt_o;

    always #5 clk = ~clk;

    vpu_lane_ctrl #(.OPERAND_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_opcode_i(req_opcode_i), .req_operand_i(req_operand_i),
        .req_operand_valid_i(req_operand_valid_i),
        .lane_start_o(lane_start_o), .lane_op_o(lane_op_o),
        .lane_operand_o(lane_operand_o), .lane_operand_valid_o(lane_operand_valid_o),
        .lane_dout_i(lane_dout_i), .lane_done_i(lane_done_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .done_cnt_o(done_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lane model: raises done lane_dly cycles after seeing start (0 = same cycle, <0 = never).
    // Outside ISSUE/WAIT it toggles done with junk data, which the controller must ignore.
    int           lane_dly = 0;
    logic [W-1:0] lane_val = '0;
    int           starts   = 0;
    bit           pend     = 1'b0;
    int           pcnt     = 0;
    bit           noise_en = 1'b1;

    always @(negedge clk) begin
        lane_done_i = 1'b0;
        if (lane_start_o) begin
            starts++;
            pend = (lane_dly >= 0);
            pcnt = 0;
        end
        if (pend) begin
            if (pcnt == lane_dly) begin
                lane_done_i = 1'b1;
                lane_dout_i = lane_val;
                pend = 1'b0;
            end else begin
                pcnt++;
            end
        end else if (noise_en && !(busy_o && !rsp_valid_o)) begin
            lane_done_i = 1'($urandom_range(0, 1));
            lane_dout_i = $urandom;
        end
    end

    logic [15:0] exp_cnt = '0;

    // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
    task automatic do_op(input string tag, input logic [3:0] opc, input logic [2:0][W-1:0] ops,
                         input logic [2:0] msk, input logic [W-1:0] dout, input int dly, input int rdy_dly);
        bit           legal, exp_err, ok;
        int           exp_lat, exp_starts, start0, cyc;
        logic [W-1:0] exp_data;
        logic [8:0]   exp_op;

        legal = (opc <= 4'd8);
        if (!legal) begin
            exp_lat = 1; exp_err = 1'b1; exp_data = '0; exp_starts = 0; exp_op = '0;
        end else begin
            exp_starts = 1;
            exp_op = 9'd1 << opc;
            if (TMO_EN && (dly < 0 || dly > TMO)) begin
                exp_lat = 2 + TMO; exp_err = 1'b1; exp_data = '0;
            end else begin
                exp_lat = 2 + dly; exp_err = 1'b0; exp_data = dout;
            end
        end

        check($sformatf("%s.ready", tag), 128'(req_ready_o), 128'(1));
        lane_dly = dly;
        lane_val = dout;
        start0   = starts;
        req_valid_i = 1'b1; req_opcode_i = opc; req_operand_i = ops; req_operand_valid_i = msk;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_opcode_i = 4'($urandom);
        req_operand_i = {$urandom, $urandom, $urandom};
        req_operand_valid_i = 3'($urandom);
        cyc = 1;
        ok = 1'b1;
        check($sformatf("%s.start", tag), 128'(lane_start_o), 128'(legal));
        if (legal) begin
            check($sformatf("%s.op", tag), 128'(lane_op_o), 128'(exp_op));
            check($sformatf("%s.operands", tag), 128'(lane_operand_o), 128'(ops));
            check($sformatf("%s.mask", tag), 128'(lane_operand_valid_o), 128'(msk));
        end
        while (rsp_valid_o !== 1'b1 && cyc < 300) begin
            if (lane_op_o !== exp_op || lane_operand_o !== ops || lane_operand_valid_o !== msk
                || req_ready_o !== 1'b0 || busy_o !== 1'b1) ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s.latency", tag), 128'(cyc), 128'(exp_lat));
        check($sformatf("%s.data", tag), 128'(rsp_data_o), 128'(exp_data));
        check($sformatf("%s.err", tag), 128'(rsp_err_o), 128'(exp_err));
        for (int i = 0; i < rdy_dly; i++) begin
            rsp_ready_i = 1'b0;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp_data || rsp_err_o !== exp_err
                || req_ready_o !== 1'b0 || lane_start_o !== 1'b0 || lane_op_o !== exp_op) ok = 1'b0;
            @(negedge clk);
        end
        check($sformatf("%s.valid_held", tag), 128'(rsp_valid_o), 128'(1));
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check($sformatf("%s.stable", tag), 128'(ok), 128'(1));
        check($sformatf("%s.valid_drop", tag), 128'(rsp_valid_o), 128'(0));
        check($sformatf("%s.idle_op", tag), 128'(lane_op_o), 128'(0));
        check($sformatf("%s.busy", tag), 128'(busy_o), 128'(0));
        check($sformatf("%s.done_cnt", tag), 128'(done_cnt_o), 128'(exp_cnt));
        check($sformatf("%s.n_starts", tag), 128'(starts - start0), 128'(exp_starts));
    endtask

    task automatic rand_op(input string tag);
        do_op(tag, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom},
              3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 6), $urandom_range(0, 3));
    endtask

    bit bad;

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_opcode_i = '0; req_operand_i = '0; req_operand_valid_i = '0;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        check("rst.ready", 128'(req_ready_o), 128'(0));
        check("rst.busy", 128'(busy_o), 128'(0));
        check("rst.valid", 128'(rsp_valid_o), 128'(0));
        check("rst.op", 128'(lane_op_o), 128'(0));
        check("rst.done_cnt", 128'(done_cnt_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.ready", 128'(req_ready_o), 128'(1));

        do_op("mul", 4'd2, {32'h0, 32'h40400000, 32'h40000000}, 3'b011, 32'h40C00000, 3, 0);
        do_op("illegal12", 4'd12, {$urandom, $urandom, $urandom}, 3'b111, $urandom, 2, 0);
        do_op("sqrt_fast", 4'd6, {$urandom, $urandom, 32'h3F800000}, 3'b001, 32'h3F800000, 0, 0);
        do_op("hold5", 4'd4, {$urandom, $urandom, $urandom}, 3'b011, $urandom, 1, 5);
        do_op("after_hold", 4'd8, {$urandom, $urandom, $urandom}, 3'b001, $urandom, 2, 0);
        do_op("illegal15", 4'd15, {$urandom, $urandom, $urandom}, 3'b000, $urandom, 0, 3);

        for (int k = 0; k < 40; k++) rand_op($sformatf("rnd%0d", k));

`ifdef VPU_LANE_CTRL_TIMEOUT_EN
        do_op("tmo_never", 4'd3, {$urandom, $urandom, $urandom}, 3'b011, $urandom, -1, 1);
        do_op("tmo_done_last", 4'd7, {$urandom, $urandom, $urandom}, 3'b001, 32'hCAFE0001, TMO, 0);
        do_op("tmo_done_late", 4'd5, {$urandom, $urandom, $urandom}, 3'b011, 32'hCAFE0002, TMO + 1, 0);
`endif

        // Reset in the middle of WAIT, with the lane answering afterwards.
        lane_dly = 8;
        lane_val = 32'hDEADBEEF;
        req_valid_i = 1'b1; req_opcode_i = 4'd0; req_operand_i = {$urandom, $urandom, $urandom};
        req_operand_valid_i = 3'b011;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.busy_before", 128'(busy_o), 128'(1));
        rst = 1'b1;
        #1;
        check("midrst.busy", 128'(busy_o), 128'(0));
        check("midrst.ready", 128'(req_ready_o), 128'(0));
        check("midrst.op", 128'(lane_op_o), 128'(0));
        check("midrst.operands", 128'(lane_operand_o), 128'(0));
        check("midrst.mask", 128'(lane_operand_valid_o), 128'(0));
        check("midrst.valid", 128'(rsp_valid_o), 128'(0));
        check("midrst.data", 128'(rsp_data_o), 128'(0));
        check("midrst.err", 128'(rsp_err_o), 128'(0));
        check("midrst.done_cnt", 128'(done_cnt_o), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || lane_start_o !== 1'b0
                || lane_op_o !== 9'd0 || rsp_data_o !== '0 || req_ready_o !== 1'b1) bad = 1'b1;
        end
        check("midrst.late_done_ignored", 128'(bad), 128'(0));
        check("midrst.cnt_after", 128'(done_cnt_o), 128'(0));

        // Preload the completion counter to its maximum to see it wrap.
        force dut.done_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.done_cnt_q;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        check("wrap.preset", 128'(done_cnt_o), 128'(16'hFFFF));
        do_op("wrap", 4'd1, {$urandom, $urandom, $urandom}, 3'b011, $urandom, 1, 0);
        check("wrap.zero", 128'(done_cnt_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
